fifo_write_arbiter: RTL and testbench

Round-robin write arbiter that shares one SyncFIFO write port among NumReq requesters, e.g. the LSU, fetch-refill and DMA paths.
- Each requester uses a valid/ready handshake with a Last flag, so multi-beat packets are written to the FIFO contiguously.
- A single registered output stage drives FifoWInc/FifoWData.
- FifoWInc is never asserted while FifoWFull is high. The FIFO RAM writes on WInc regardless of full, so this gating is what protects the FIFO.

---
 rtl/fifo_write_arbiter_pkg.sv | 17 +
 rtl/fifo_write_arbiter_rr_picker.sv | 28 ++
 rtl/fifo_write_arbiter.sv | 154 +++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM state encodings,
// statistics counter width and the grant-id width helper.
package fifo_write_arbiter_pkg;

    // Arbitration FSM states (legacy single-bit encoding)
    localparam logic ARB  = 1'b0;
    localparam logic HOLD = 1'b1;

    // Width of each per-requester accepted-beat counter
    localparam int StatWidth = 16;

    // Grant id width; a single requester still needs one bit
    function automatic int grant_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Round-robin picker: finds the first valid requester after LastGrant,
// wrapping modulo NumReq. Purely combinational so other arbiters can reuse it.
module rr_picker #(
    parameter int NumReq  = 4,
    parameter int IdWidth = 2
) (
    input  logic [NumReq-1:0]  ReqValid,
    input  logic [IdWidth-1:0] LastGrant,
    output logic [IdWidth-1:0] PickId,
    output logic               PickValid
);

    // Scan from the farthest position back to the nearest so the nearest wins
    always_comb begin
        logic [IdWidth-1:0] idx;
        PickId    = '0;
        PickValid = 1'b0;
        idx       = '0;
        for (int k = NumReq; k >= 1; k--) begin
            idx = IdWidth'((int'(LastGrant) + k) % NumReq);
            if (ReqValid[idx]) begin
                PickId    = idx;
                PickValid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one SyncFIFO write port among NumReq
// requesters. Multi-beat packets (terminated by ReqLast) lock the grant so
// the packet lands in the FIFO contiguously. One registered output stage
// drives FifoWInc/FifoWData; WInc is gated by WFull because the FIFO RAM
// writes on WInc regardless of full.
// Optional build macro: FIFO_ARB_STATS_EN adds StatBeats, a saturating
// per-requester count of accepted beats.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int  NumReq       = 4,
    parameter int  DataWidth    = 64,
    localparam int GrantIdWidth = grant_id_width(NumReq)
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic [NumReq-1:0]           ReqValid,
    input  logic [NumReq-1:0]           ReqLast,
    input  logic [NumReq*DataWidth-1:0] ReqData,
    output logic [NumReq-1:0]           ReqReady,
    output logic                        FifoWInc,
    output logic [DataWidth-1:0]        FifoWData,
    input  logic                        FifoWFull,
    output logic [GrantIdWidth-1:0]     GrantId,
`ifdef FIFO_ARB_STATS_EN
    output logic [NumReq*StatWidth-1:0] StatBeats,
`endif
    output logic                        Locked
);

    logic                    state_q;
    logic [GrantIdWidth-1:0] last_grant_q;
    logic [GrantIdWidth-1:0] grant_q;
    logic [GrantIdWidth-1:0] pick_id;
    logic                    pick_valid;
    logic                    stage_free;
    logic                    accept;
    logic                    acc_last;
    logic [DataWidth-1:0]    acc_data;
    logic                    out_vld_p1;
    logic [DataWidth-1:0]    out_data_p1;

    rr_picker #(
        .NumReq  (NumReq),
        .IdWidth (GrantIdWidth)
    ) u_picker (
        .ReqValid  (ReqValid),
        .LastGrant (last_grant_q),
        .PickId    (pick_id),
        .PickValid (pick_valid)
    );

    // Output stage can take a beat when empty or when it drains this cycle
    assign FifoWInc   = out_vld_p1 & ~FifoWFull;
    assign stage_free = ~out_vld_p1 | FifoWInc;
    assign FifoWData  = out_data_p1;
    assign Locked     = (state_q == HOLD);

    // Current grant: locked id in HOLD, fresh pick in ARB, else keep the old id
    always_comb begin
        if (state_q == HOLD) begin
            GrantId = grant_q;
        end else if (pick_valid) begin
            GrantId = pick_id;
        end else begin
            GrantId = grant_q;
        end
    end

    // Ready to the granted requester only; in HOLD it is offered even without valid
    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            ReqReady[i] = (GrantIdWidth'(i) == GrantId) & stage_free &
                          ((state_q == HOLD) | ReqValid[i]);
        end
    end

    // Steer the accepted beat; ReqReady is one-hot so the OR-mux is exact
    always_comb begin
        accept   = 1'b0;
        acc_last = 1'b0;
        acc_data = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (ReqReady[i] & ReqValid[i]) begin
                accept   = 1'b1;
                acc_last = ReqLast[i];
                acc_data = ReqData[i*DataWidth +: DataWidth];
            end
        end
    end

    // Stage p1: registered write port, holds its beat while the FIFO is full
    always_ff @(posedge Clk) begin
        if (Rst) begin
            out_vld_p1  <= 1'b0;
            out_data_p1 <= '0;
        end else if (accept) begin
            out_vld_p1  <= 1'b1;
            out_data_p1 <= acc_data;
        end else if (FifoWInc) begin
            out_vld_p1  <= 1'b0;
        end
    end

    // Arbitration FSM: lock on a non-last beat, release and rotate on the last one
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= ARB;
            last_grant_q <= GrantIdWidth'(NumReq - 1);
            grant_q      <= '0;
        end else begin
            grant_q <= GrantId;
            if (accept) begin
                if (acc_last) begin
                    state_q      <= ARB;
                    last_grant_q <= GrantId;
                end else begin
                    state_q      <= HOLD;
                end
            end
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [StatWidth-1:0] stat_cnt [NumReq];

    function automatic logic [StatWidth-1:0] stat_sat_inc(input logic [StatWidth-1:0] v);
        return (v == '1) ? v : v + StatWidth'(1);
    endfunction

    // Per-requester accepted-beat counters, sticking at all-ones
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NumReq; i++) begin
                stat_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumReq; i++) begin
                if (ReqValid[i] & ReqReady[i]) begin
                    stat_cnt[i] <= stat_sat_inc(stat_cnt[i]);
                end
            end
        end
    end

    // Flatten the counters onto the statistics port
    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            StatBeats[i*StatWidth +: StatWidth] = stat_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Testbench for fifo_write_arbiter: queued requesters with randomized
// presentation, a behavioural arbiter model, directed scenarios and a
// randomized soak. Define FIFO_ARB_STATS_EN to also exercise StatBeats.
module tb_fifo_write_arbiter;

    localparam int N = 4;
    localparam int W = 64;

    typedef struct packed {
        logic         last;
        logic [W-1:0] data;
    } beat_t;

    logic           Clk = 1'b0;
    logic           Rst = 1'b0;
    logic [N-1:0]   ReqValid = '0;
    logic [N-1:0]   ReqLast = '0;
    logic [N*W-1:0] ReqData = '0;
    logic [N-1:0]   ReqReady;
    logic           FifoWInc;
    logic [W-1:0]   FifoWData;
    logic           FifoWFull = 1'b0;
    logic [1:0]     GrantId;
    logic           Locked;
`ifdef FIFO_ARB_STATS_EN
    logic [N*16-1:0] StatBeats;
`endif

    fifo_write_arbiter #(.NumReq(N), .DataWidth(W)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .ReqValid  (ReqValid),
        .ReqLast   (ReqLast),
        .ReqData   (ReqData),
        .ReqReady  (ReqReady),
        .FifoWInc  (FifoWInc),
        .FifoWData (FifoWData),
        .FifoWFull (FifoWFull),
        .GrantId   (GrantId),
`ifdef FIFO_ARB_STATS_EN
        .StatBeats (StatBeats),
`endif
        .Locked    (Locked)
    );

    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;

    // Requester side: pending beats per requester and whether one is on the bus
    beat_t rq [N][$];
    bit    pres [N];
    int    rate = 100;

    // Logs of what the model accepted and what the DUT wrote into the FIFO
    int           acc_log [$];
    logic [W-1:0] wr_log [$];

    // Behavioural model of the arbiter
    bit           m_hold = 0;
    int           m_lock = 0;
    int           m_last = N - 1;
    int           m_gid = 0;
    bit           m_ov = 0;
    logic [W-1:0] m_od = '0;
    int           m_cnt [N];

    bit           e_winc;
    bit           e_free;
    int           e_gid;
    logic [N-1:0] e_ready;

    function automatic beat_t mk(input logic [W-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        return b;
    endfunction

    function automatic bit valid_at(input int idx);
        return ((ReqValid >> idx) & 1) != 0;
    endfunction

    // Expected combinational outputs for the current inputs and model state
    function automatic void model_eval();
        int cand;
        e_winc = m_ov && !FifoWFull;
        e_free = !m_ov || e_winc;
        e_gid  = m_gid;
        if (m_hold) begin
            e_gid = m_lock;
        end else begin
            for (int k = 1; k <= N; k++) begin
                cand = (m_last + k) % N;
                if (valid_at(cand)) begin
                    e_gid = cand;
                    break;
                end
            end
        end
        e_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (i == e_gid && e_free && (m_hold || valid_at(i))) e_ready = e_ready | (N'(1) << i);
        end
    endfunction

    // Put the front beat of each requester on the bus; valid held until accepted
    task automatic present();
        for (int i = 0; i < N; i++) begin
            if (!pres[i] && rq[i].size() > 0 && $urandom_range(99) < rate) pres[i] = 1;
            if (pres[i]) begin
                ReqValid[i]          = 1'b1;
                ReqLast[i]           = rq[i][0].last;
                ReqData[i*W +: W]    = rq[i][0].data;
            end else begin
                ReqValid[i]          = 1'b0;
                ReqLast[i]           = 1'($urandom_range(1));
                ReqData[i*W +: W]    = {$urandom, $urandom};
            end
        end
    endtask

    // One clock: sample at the falling edge, advance model and requesters at the rising edge
    task automatic tick();
        logic [N-1:0] acc;
        bit           macc;
        @(negedge Clk);
        model_eval();
        acc  = ReqValid & ReqReady;
        macc = (e_ready & ReqValid) != '0;
        if (FifoWInc) wr_log.push_back(FifoWData);
        @(posedge Clk);
        if (Rst) begin
            m_hold = 0; m_lock = 0; m_last = N - 1; m_gid = 0; m_ov = 0; m_od = '0;
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = 0;
                rq[i].delete();
                pres[i] = 0;
            end
        end else begin
            if (macc) begin
                acc_log.push_back(e_gid);
                if (m_cnt[e_gid] < 65535) m_cnt[e_gid]++;
                m_od = ReqData[e_gid*W +: W];
                m_ov = 1;
                if (((ReqLast >> e_gid) & 1) != 0) begin
                    m_hold = 0;
                    m_last = e_gid;
                end else begin
                    m_hold = 1;
                    m_lock = e_gid;
                end
            end else if (e_winc) begin
                m_ov = 0;
            end
            m_gid = e_gid;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    void'(rq[i].pop_front());
                    pres[i] = 0;
                end
            end
        end
        #1;
        present();
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        tick();
        tick();
        Rst = 1'b0;
        #1;
        for (int r = 0; r < 3; r++) begin
            vectors += 4;
            if (FifoWInc !== 1'b0) begin miscompares++; $display("FAIL reset_winc: got %b want 0", FifoWInc); end
            if (Locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b want 0", Locked); end
            if (GrantId !== 2'd0) begin miscompares++; $display("FAIL reset_grant: got %0d want 0", GrantId); end
            if (ReqReady !== 4'b0000) begin miscompares++; $display("FAIL reset_ready: got %b want 0000", ReqReady); end
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] tags [5];
        int           ids [5];
        int           n;
        tags = '{64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hB0};
        ids  = '{0, 1, 2, 3, 0};
        rate = 100;
        FifoWFull = 1'b0;
        for (int i = 0; i < 4; i++) rq[i].push_back(mk(tags[i], 1'b1));
        rq[0].push_back(mk(tags[4], 1'b1));
        acc_log.delete();
        wr_log.delete();
        present();
        #1;
        for (int c = 0; c < 10; c++) begin
            n = acc_log.size();
            tick();
            if (acc_log.size() > n && n < 5) begin
                vectors++;
                if (FifoWInc !== 1'b1 || FifoWData !== tags[n]) begin
                    miscompares++;
                    $display("FAIL rr_latency beat %0d: winc=%b data=%h want winc=1 data=%h", n, FifoWInc, FifoWData, tags[n]);
                end
            end
        end
        for (int k = 0; k < 5; k++) begin
            vectors += 2;
            if (k >= acc_log.size() || acc_log[k] != ids[k]) begin
                miscompares++;
                $display("FAIL rr_grant_order %0d: got %0d want %0d", k, (k < acc_log.size()) ? acc_log[k] : -1, ids[k]);
            end
            if (k >= wr_log.size() || wr_log[k] !== tags[k]) begin
                miscompares++;
                $display("FAIL rr_write_order %0d: got %h want %h", k, (k < wr_log.size()) ? wr_log[k] : '0, tags[k]);
            end
        end
        vectors++;
        if (wr_log.size() != 5) begin miscompares++; $display("FAIL rr_write_count: got %0d want 5", wr_log.size()); end
    endtask

    task automatic test_multibeat();
        logic [W-1:0] tags [5];
        int           ids [5];
        int           n;
        tags = '{64'hC1A, 64'hC1B, 64'hC1C, 64'hC2, 64'hC0};
        ids  = '{1, 1, 1, 2, 0};
        rq[1].push_back(mk(tags[0], 1'b0));
        rq[1].push_back(mk(tags[1], 1'b0));
        rq[1].push_back(mk(tags[2], 1'b1));
        rq[2].push_back(mk(tags[3], 1'b1));
        rq[0].push_back(mk(tags[4], 1'b1));
        acc_log.delete();
        wr_log.delete();
        present();
        #1;
        for (int c = 0; c < 12; c++) begin
            n = acc_log.size();
            tick();
            if (n == 0 && acc_log.size() == 1) begin
                vectors += 2;
                if (Locked !== 1'b1) begin miscompares++; $display("FAIL mb_locked: got %b want 1", Locked); end
                if (GrantId !== 2'd1) begin miscompares++; $display("FAIL mb_locked_id: got %0d want 1", GrantId); end
            end
        end
        for (int k = 0; k < 5; k++) begin
            vectors += 2;
            if (k >= acc_log.size() || acc_log[k] != ids[k]) begin
                miscompares++;
                $display("FAIL mb_grant_order %0d: got %0d want %0d", k, (k < acc_log.size()) ? acc_log[k] : -1, ids[k]);
            end
            if (k >= wr_log.size() || wr_log[k] !== tags[k]) begin
                miscompares++;
                $display("FAIL mb_write_order %0d: got %h want %h", k, (k < wr_log.size()) ? wr_log[k] : '0, tags[k]);
            end
        end
        vectors++;
        if (Locked !== 1'b0) begin miscompares++; $display("FAIL mb_unlocked: got %b want 0", Locked); end
    endtask

    task automatic test_full_stall();
        logic [W-1:0] tags [3];
        tags = '{64'hE2, 64'hE0, 64'hE1};
        rq[0].push_back(mk(tags[1], 1'b1));
        rq[0].push_back(mk(tags[2], 1'b1));
        rq[2].push_back(mk(tags[0], 1'b1));
        acc_log.delete();
        wr_log.delete();
        present();
        #1;
        tick();
        FifoWFull = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            vectors += 2;
            if (FifoWInc !== 1'b0) begin miscompares++; $display("FAIL full_winc cycle %0d: got %b want 0", c, FifoWInc); end
            if (ReqReady !== 4'b0000) begin miscompares++; $display("FAIL full_ready cycle %0d: got %b want 0000", c, ReqReady); end
            tick();
        end
        FifoWFull = 1'b0;
        #1;
        vectors += 3;
        if (FifoWInc !== 1'b1) begin miscompares++; $display("FAIL full_drop_winc: got %b want 1", FifoWInc); end
        if (FifoWData !== tags[0]) begin miscompares++; $display("FAIL full_drop_data: got %h want %h", FifoWData, tags[0]); end
        if (ReqReady !== 4'b0001) begin miscompares++; $display("FAIL full_drop_ready: got %b want 0001", ReqReady); end
        repeat (6) tick();
        vectors++;
        if (wr_log.size() != 3) begin miscompares++; $display("FAIL full_write_count: got %0d want 3", wr_log.size()); end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (k >= wr_log.size() || wr_log[k] !== tags[k]) begin
                miscompares++;
                $display("FAIL full_write_order %0d: got %h want %h", k, (k < wr_log.size()) ? wr_log[k] : '0, tags[k]);
            end
        end
    endtask

    task automatic test_reset_in_hold();
        rq[2].push_back(mk(64'hF0, 1'b0));
        rq[2].push_back(mk(64'hF1, 1'b1));
        present();
        #1;
        tick();
        vectors += 2;
        if (Locked !== 1'b1) begin miscompares++; $display("FAIL hold_locked: got %b want 1", Locked); end
        if (FifoWInc !== 1'b1) begin miscompares++; $display("FAIL hold_winc: got %b want 1", FifoWInc); end
        FifoWFull = 1'b1;
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        FifoWFull = 1'b0;
        #1;
        vectors += 4;
        if (Locked !== 1'b0) begin miscompares++; $display("FAIL rst_hold_locked: got %b want 0", Locked); end
        if (FifoWInc !== 1'b0) begin miscompares++; $display("FAIL rst_hold_winc: got %b want 0", FifoWInc); end
        if (FifoWData !== 64'h0) begin miscompares++; $display("FAIL rst_hold_data: got %h want 0", FifoWData); end
        if (GrantId !== 2'd0) begin miscompares++; $display("FAIL rst_hold_grant: got %0d want 0", GrantId); end
        rq[3].push_back(mk(64'hD3, 1'b1));
        rq[0].push_back(mk(64'hD0, 1'b1));
        wr_log.delete();
        present();
        #1;
        vectors += 2;
        if (GrantId !== 2'd0) begin miscompares++; $display("FAIL rst_prio_grant: got %0d want 0", GrantId); end
        if (ReqReady !== 4'b0001) begin miscompares++; $display("FAIL rst_prio_ready: got %b want 0001", ReqReady); end
        repeat (4) tick();
        vectors += 2;
        if (wr_log.size() < 1 || wr_log[0] !== 64'hD0) begin miscompares++; $display("FAIL rst_prio_first_write: got %h want d0", (wr_log.size() > 0) ? wr_log[0] : '0); end
        if (wr_log.size() < 2 || wr_log[1] !== 64'hD3) begin miscompares++; $display("FAIL rst_prio_second_write: got %h want d3", (wr_log.size() > 1) ? wr_log[1] : '0); end
    endtask

    task automatic test_random();
        int serial = 0;
        int len;
        rate = 60;
        for (int c = 0; c < 800; c++) begin
            FifoWFull = ($urandom_range(99) < 30);
            Rst = ($urandom_range(199) == 0);
            for (int i = 0; i < N; i++) begin
                if (rq[i].size() == 0 && $urandom_range(2) == 0) begin
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) begin
                        rq[i].push_back(mk({8'(i), 24'(serial), 32'($urandom)}, b == len - 1));
                        serial++;
                    end
                end
            end
            #1;
            model_eval();
            vectors += 5;
            if (ReqReady !== e_ready) begin miscompares++; $display("FAIL rnd_ready cycle %0d: got %b want %b", c, ReqReady, e_ready); end
            if (FifoWInc !== e_winc) begin miscompares++; $display("FAIL rnd_winc cycle %0d: got %b want %b", c, FifoWInc, e_winc); end
            if (FifoWData !== m_od) begin miscompares++; $display("FAIL rnd_data cycle %0d: got %h want %h", c, FifoWData, m_od); end
            if (GrantId !== 2'(e_gid)) begin miscompares++; $display("FAIL rnd_grant cycle %0d: got %0d want %0d", c, GrantId, e_gid); end
            if (Locked !== m_hold) begin miscompares++; $display("FAIL rnd_locked cycle %0d: got %b want %b", c, Locked, m_hold); end
            tick();
        end
        Rst = 1'b0;
        FifoWFull = 1'b0;
    endtask

`ifdef FIFO_ARB_STATS_EN
    task automatic test_stats();
        int budget = 0;
        rate = 100;
        FifoWFull = 1'b0;
        Rst = 1'b0;
        repeat (20) tick();
        for (int i = 0; i < N; i++) rq[i].delete();
        for (int k = 0; k < 70000; k++) rq[3].push_back(mk(64'(k), 1'b1));
        present();
        #1;
        while ((rq[3].size() > 0 || pres[3]) && budget < 80000) begin
            tick();
            budget++;
        end
        vectors++;
        if (budget >= 80000) begin miscompares++; $display("FAIL stats_timeout: %0d beats left, want 0", rq[3].size()); end
        repeat (3) tick();
        vectors++;
        if (StatBeats[3*16 +: 16] !== 16'hFFFF) begin miscompares++; $display("FAIL stats_sat: got %h want ffff", StatBeats[3*16 +: 16]); end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (StatBeats[i*16 +: 16] !== 16'(m_cnt[i])) begin
                miscompares++;
                $display("FAIL stats_count %0d: got %h want %h", i, StatBeats[i*16 +: 16], 16'(m_cnt[i]));
            end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            pres[i] = 0;
        end
        test_reset();
        test_round_robin();
        test_multibeat();
        test_full_stall();
        test_reset_in_hold();
        test_random();
`ifdef FIFO_ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
